// File: rtl/delay_pipe_pkg.sv
// Helpers shared by the delay_pipe block: run-time tap clamping.
package delay_pipe_pkg;

  // Map a requested latency onto the legal range 1..depth.
  function automatic int unsigned clamp_tap(input int unsigned sel,
                                            input int unsigned depth);
    int unsigned eff;
    eff = sel;
    if (eff < 1) begin
      eff = 1;
    end
    if (eff > depth) begin
      eff = depth;
    end
    return eff;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One {valid, data} register of the delay line, advancing only when enabled.
module pipe_stage #(
  parameter int unsigned WIDTH      = 32,
  parameter bit          RESET_DATA = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             d_valid,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic [WIDTH-1:0] q_data
);

  // Valid bit: flush wins over shift, stall holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
    end else if (en) begin
      q_valid <= d_valid & ~clr;
    end
  end

  // Data keeps shifting during a flush; its content is irrelevant once invalid.
  generate
    if (RESET_DATA) begin : g_data_rst
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_data <= '0;
        end else if (en) begin
          q_data <= d_data;
        end
      end
    end else begin : g_data_norst
      always_ff @(posedge clk) begin
        if (en) begin
          q_data <= d_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/delay_pipe.sv
// Stallable, flushable delay line with a run-time selectable output tap
// and an occupancy counter covering every stage.
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 16,
  parameter bit          RESET_DATA = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(DEPTH+1)-1:0] delay_sel,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occ
);

  localparam int unsigned SEL_W = $clog2(DEPTH + 1);
  localparam int unsigned CNT_W = SEL_W;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0] stage_valid;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic [IDX_W-1:0] tap_idx_c;

  // Stage 0 captures the input; every later stage copies its predecessor.
  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             d_valid;
      logic [WIDTH-1:0] d_data;

      if (i == 0) begin : g_head
        assign d_valid = in_valid;
        assign d_data  = in_data;
      end else begin : g_body
        assign d_valid = stage_valid[i-1];
        assign d_data  = stage_data[i-1];
      end

      pipe_stage #(
        .WIDTH      (WIDTH),
        .RESET_DATA (RESET_DATA)
      ) u_stage (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .clr     (clr),
        .d_valid (d_valid),
        .d_data  (d_data),
        .q_valid (stage_valid[i]),
        .q_data  (stage_data[i])
      );
    end
  endgenerate

  // Tap mux straight from the stage registers; a new delay_sel acts at once.
  always_comb begin
    tap_idx_c = IDX_W'(clamp_tap(32'(delay_sel), DEPTH) - 32'd1);
    out_valid = stage_valid[tap_idx_c];
    out_data  = stage_data[tap_idx_c];
  end

  // Occupancy tracks words entering stage 0 versus words leaving the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ <= '0;
    end else if (en) begin
      if (clr) begin
        occ <= '0;
      end else if (in_valid && !stage_valid[DEPTH-1]) begin
        occ <= occ + CNT_W'(1);
      end else if (!in_valid && stage_valid[DEPTH-1]) begin
        occ <= occ - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_delay_pipe.sv
// Self-checking bench for delay_pipe (WIDTH=8, DEPTH=4): directed scenarios
// with literal expectations plus randomized traffic against a queue-style model.
module tb_delay_pipe;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned SEL_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             clr;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic [SEL_W-1:0] delay_sel;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [SEL_W-1:0] occ;

  int n_cmp = 0;
  int n_err = 0;
  bit run_cmp = 1'b0;

  // Model: history of what each stage holds, newest first.
  bit             mv [DEPTH];
  bit [WIDTH-1:0] md [DEPTH];

  delay_pipe #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .RESET_DATA (1'b1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .delay_sel (delay_sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occ       (occ)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mv[i] = 1'b0;
        md[i] = '0;
      end
    end else if (en) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        mv[i] = clr ? 1'b0 : mv[i-1];
        md[i] = md[i-1];
      end
      mv[0] = clr ? 1'b0 : in_valid;
      md[0] = in_data;
    end
  end

  function automatic int model_eff(input int sel);
    if (sel < 1) return 1;
    if (sel > DEPTH) return DEPTH;
    return sel;
  endfunction

  function automatic int model_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mv[i]);
    return n;
  endfunction

  task automatic lit(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the clock edge.
  always @(posedge clk) begin
    #2;
    if (run_cmp) begin
      int e;
      e = model_eff(int'(delay_sel));
      lit("model_occ", int'(occ), model_occ());
      lit("model_out_valid", int'(out_valid), int'(mv[e-1]));
      if (mv[e-1]) lit("model_out_data", int'(out_data), int'(md[e-1]));
    end
  end

  task automatic cyc(input bit e, input bit c, input bit v, input int d);
    en       = e;
    clr      = c;
    in_valid = v;
    in_data  = WIDTH'(d);
    @(posedge clk);
    #3;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    delay_sel = SEL_W'(1);
    #1;
    lit("reset_out_valid", int'(out_valid), 0);
    lit("reset_occ", int'(occ), 0);
    lit("reset_out_data", int'(out_data), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    run_cmp = 1'b1;

    // Latency 3
    delay_sel = SEL_W'(3);
    cyc(1, 0, 1, 'h11);
    lit("lat_e1_valid", int'(out_valid), 0);
    cyc(1, 0, 1, 'h22);
    lit("lat_e2_valid", int'(out_valid), 0);
    cyc(1, 0, 1, 'h33);
    lit("lat_e3_valid", int'(out_valid), 1);
    lit("lat_e3_data", int'(out_data), 'h11);
    cyc(1, 0, 1, 'h44);
    lit("lat_e4_data", int'(out_data), 'h22);

    // Stall with delay 2
    cyc(1, 1, 0, 0);
    delay_sel = SEL_W'(2);
    cyc(1, 0, 1, 'h55);
    lit("stall_e1_valid", int'(out_valid), 0);
    cyc(0, 0, 1, 'hFF);
    lit("stall_e2_occ", int'(occ), 1);
    lit("stall_e2_valid", int'(out_valid), 0);
    cyc(0, 0, 1, 'hFF);
    lit("stall_e3_occ", int'(occ), 1);
    cyc(1, 0, 0, 0);
    lit("stall_e4_valid", int'(out_valid), 1);
    lit("stall_e4_data", int'(out_data), 'h55);

    // Flush with three words in flight
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 'h61);
    cyc(1, 0, 1, 'h62);
    cyc(1, 0, 1, 'h63);
    lit("flush_pre_occ", int'(occ), 3);
    cyc(1, 1, 1, 'h77);
    lit("flush_occ", int'(occ), 0);
    for (int s = 0; s < 8; s++) begin
      delay_sel = SEL_W'(s);
      #1;
      lit("flush_out_valid", int'(out_valid), 0);
    end
    for (int k = 0; k < 4; k++) cyc(1, 0, 0, 0);
    lit("flush_drain_occ", int'(occ), 0);

    // Clamp: 0 behaves as 1, 7 behaves as 4
    delay_sel = SEL_W'(0);
    cyc(1, 0, 1, 'hC3);
    lit("clamp0_valid", int'(out_valid), 1);
    lit("clamp0_data", int'(out_data), 'hC3);
    delay_sel = SEL_W'(7);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    lit("clamp7_early_valid", int'(out_valid), 0);
    cyc(1, 0, 0, 0);
    lit("clamp7_valid", int'(out_valid), 1);
    lit("clamp7_data", int'(out_data), 'hC3);

    // Occupancy saturation and drain
    cyc(1, 1, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc(1, 0, 1, k);
      lit("occ_fill", int'(occ), (k < 4) ? k : 4);
    end
    cyc(1, 0, 0, 0);
    lit("occ_bubble", int'(occ), 3);
    for (int k = 2; k >= -1; k--) begin
      cyc(1, 0, 0, 0);
      lit("occ_drain", int'(occ), (k > 0) ? k : 0);
    end

    // Reset mid-operation
    delay_sel = SEL_W'(4);
    for (int k = 0; k < 4; k++) cyc(1, 0, 1, 'hA1 + k);
    lit("rstmid_pre_data", int'(out_data), 'hA1);
    lit("rstmid_pre_occ", int'(occ), 4);
    rst_n = 1'b0;
    #1;
    lit("rstmid_valid", int'(out_valid), 0);
    lit("rstmid_occ", int'(occ), 0);
    lit("rstmid_data", int'(out_data), 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    delay_sel = SEL_W'(1);
    cyc(1, 0, 0, 0);
    lit("rstmid_post_valid", int'(out_valid), 0);
    cyc(1, 0, 1, 'hB1);
    lit("rstmid_new_valid", int'(out_valid), 1);
    lit("rstmid_new_data", int'(out_data), 'hB1);

    // Randomized traffic, including mid-stream tap changes
    for (int k = 0; k < 600; k++) begin
      delay_sel = SEL_W'($urandom_range(0, 7));
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0),
          ($urandom_range(0, 9) < 6), int'($urandom_range(0, 255)));
    end

    run_cmp = 1'b0;
    #10;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
